// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped programmable interrupt controller.
// Edge-detects NIRQ device lines into pending bits, masks and prioritises them
// (lowest index wins), and presents one request at a time to the CPU.
// Register window (word offsets from BASE):
//   0 MASK    R/W  enable per line
//   1 PENDING R/W1C pending bits
//   2 ACK     R    returns INTnum in REQ and retires the request (else all ones)
//   3 EOI     W    ends SERVICE; read returns {state, cur}
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   irq            asynchronous rising-edge interrupt lines
//   Addr           CPU address; Memread read strobe; Memwrite write code (1 = word)
//   BUS            shared 32-bit data bus, driven only during hit reads
//   INTreq/INTnum  registered request and vector to the CPU
module irq_ctrl #(
    parameter int unsigned NIRQ     = 8,
    parameter logic [31:0] BASE     = 32'hFFFF_FF00,
    parameter int unsigned VEC_BASE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  logic [31:0]     Addr,
    input  logic            Memread,
    input  logic [1:0]      Memwrite,
    inout  wire  [31:0]     BUS,
    output logic            INTreq,
    output logic [31:0]     INTnum
);

    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   cur_q;
    logic [NIRQ-1:0]    mask_q, mask_d;
    logic [NIRQ-1:0]    pend_q, pend_d;
    logic [NIRQ-1:0]    sync1_q, sync2_q, dly_q;

    logic               hit_c, wr_c, rd_c, ack_c, eoi_c, bus_en_c, keep_c;
    logic [1:0]         sel_c;
    logic [NIRQ-1:0]    rise_c, clr_c, active_c, cur_bit_c, wdata_c;
    logic [IDX_W-1:0]   win_c;
    logic [31:0]        rdata_c;
    logic               unused_c;

    // Address decode and bus strobes
    assign hit_c   = (Addr[31:4] == BASE[31:4]);
    assign sel_c   = Addr[3:2];
    assign wr_c    = hit_c && (Memwrite == 2'd1);
    assign rd_c    = hit_c && Memread;
    assign ack_c   = rd_c && (sel_c == 2'd2) && (state_q == ST_REQ);
    assign eoi_c   = wr_c && (sel_c == 2'd3);
    assign wdata_c = BUS[NIRQ-1:0];
    assign unused_c = ^{Addr[1:0], BUS};

    assign rise_c    = sync2_q & ~dly_q;
    assign active_c  = pend_q & mask_q;
    assign cur_bit_c = NIRQ'(1'b1) << cur_q;

    // Next MASK / PENDING; an edge-detect set overrides any clear in the same cycle
    always_comb begin
        mask_d = mask_q;
        clr_c  = '0;
        if (wr_c && (sel_c == 2'd0)) begin
            mask_d = wdata_c;
        end
        if (wr_c && (sel_c == 2'd1)) begin
            clr_c = wdata_c;
        end
        if (ack_c) begin
            clr_c = clr_c | cur_bit_c;
        end
        pend_d = (pend_q & ~clr_c) | rise_c;
    end

    // The request in flight survives only while its line stays pending and enabled
    assign keep_c = |(mask_d & pend_d & cur_bit_c);

    // Lowest-index winner among enabled pending lines
    always_comb begin
        win_c = '0;
        for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
            if (active_c[i]) begin
                win_c = IDX_W'(i);
            end
        end
    end

    // Read mux
    always_comb begin
        rdata_c = '0;
        case (sel_c)
            2'd0:    rdata_c = 32'(mask_q);
            2'd1:    rdata_c = 32'(pend_q);
            2'd2:    rdata_c = (state_q == ST_REQ) ? INTnum : 32'hFFFF_FFFF;
            default: rdata_c = {26'd0, state_q, cur_q};
        endcase
    end

    assign bus_en_c = rd_c && (Memwrite == 2'd0);
    assign BUS      = bus_en_c ? rdata_c : 32'bz;

    // Two-flop synchronizer plus delay flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            dly_q   <= '0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    // Software-visible registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
            pend_q <= '0;
        end else begin
            mask_q <= mask_d;
            pend_q <= pend_d;
        end
    end

    // Request state machine with registered CPU outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            INTreq  <= 1'b0;
            INTnum  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|active_c) begin
                        cur_q   <= win_c;
                        state_q <= ST_REQ;
                        INTreq  <= 1'b1;
                        INTnum  <= 32'(VEC_BASE) + 32'(win_c);
                    end
                end
                ST_REQ: begin
                    // ACK takes precedence over a same-cycle software cancel
                    if (ack_c) begin
                        state_q <= ST_SERVICE;
                        INTreq  <= 1'b0;
                    end else if (!keep_c) begin
                        state_q <= ST_IDLE;
                        INTreq  <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (eoi_c) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    INTreq  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed scenarios plus randomized traffic against
// a behavioural model of the controller.
module tb_irq_ctrl;

    localparam int unsigned NIRQ = 8;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam int unsigned VEC  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NIRQ-1:0] irq;
    logic [31:0]     Addr;
    logic            Memread;
    logic [1:0]      Memwrite;
    tri0  [31:0]     BUS;
    logic            INTreq;
    logic [31:0]     INTnum;
    logic [31:0]     tb_wdata;
    logic            tb_drv;

    int tests_run    = 0;
    int tests_failed = 0;

    assign BUS = tb_drv ? tb_wdata : 32'bz;

    always #5 clk = ~clk;

    irq_ctrl #(.NIRQ(NIRQ), .BASE(BASE), .VEC_BASE(VEC)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq),
        .Addr    (Addr),
        .Memread (Memread),
        .Memwrite(Memwrite),
        .BUS     (BUS),
        .INTreq  (INTreq),
        .INTnum  (INTnum)
    );

    // ---------------- behavioural model ----------------
    logic [NIRQ-1:0] m_mask, m_pend, h1, h2, h3;
    int              m_state, m_cur;
    logic            m_req;
    logic [31:0]     m_num;

    always @(posedge clk or posedge rst) begin : model
        logic [NIRQ-1:0] rise, clr, nmask, npend, act;
        logic hit, ack, wr;
        int sel, w;
        if (rst) begin
            m_mask = '0; m_pend = '0; h1 = '0; h2 = '0; h3 = '0;
            m_state = 0; m_cur = 0; m_req = 1'b0; m_num = '0;
        end else begin
            hit  = (Addr[31:4] == BASE[31:4]);
            sel  = int'(Addr[3:2]);
            wr   = hit && (Memwrite == 2'd1);
            // a line was low three edges ago and high two edges ago
            rise = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = irq;
            act  = m_pend & m_mask;
            ack  = hit && Memread && sel == 2 && m_state == 1;
            nmask = m_mask;
            clr   = '0;
            if (wr && sel == 0) nmask = tb_wdata[NIRQ-1:0];
            if (wr && sel == 1) clr = tb_wdata[NIRQ-1:0];
            if (ack) clr[m_cur] = 1'b1;
            npend = (m_pend & ~clr) | rise;
            case (m_state)
                0: if (act != 0) begin
                    w = -1;
                    for (int i = 0; i < int'(NIRQ); i++)
                        if (act[i] && w < 0) w = i;
                    m_cur = w; m_state = 1; m_req = 1'b1; m_num = VEC + 32'(w);
                end
                1: if (ack) begin
                    m_state = 2; m_req = 1'b0;
                end else if (!nmask[m_cur] || !npend[m_cur]) begin
                    m_state = 0; m_req = 1'b0;
                end
                default: if (wr && sel == 3) m_state = 0;
            endcase
            m_mask = nmask;
            m_pend = npend;
        end
    end

    function automatic logic [31:0] exp_rd(input int sel);
        case (sel)
            0:       return 32'(m_mask);
            1:       return 32'(m_pend);
            2:       return (m_state == 1) ? m_num : 32'hFFFF_FFFF;
            default: return {26'd0, 2'(m_state), 4'(m_cur)};
        endcase
    endfunction

    function automatic logic [31:0] ra(input int sel);
        return BASE + 32'(sel * 4);
    endfunction

    // ---------------- bus helpers (start and end on a falling edge) ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Addr = a; Memread = 1'b1;
        #1 d = BUS;
        @(negedge clk);
        Memread = 1'b0; Addr = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] code);
        Addr = a; Memwrite = code; tb_wdata = d; tb_drv = 1'b1;
        @(negedge clk);
        Memwrite = 2'd0; tb_drv = 1'b0; Addr = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d;
        tests_run++; if (INTreq !== 1'b0) begin tests_failed++; $display("FAIL reset_intreq got %b want 0", INTreq); end
        tests_run++; if (INTnum !== 32'd0) begin tests_failed++; $display("FAIL reset_intnum got %0d want 0", INTnum); end
        rd(ra(0), d);
        tests_run++; if (d !== 32'd0) begin tests_failed++; $display("FAIL reset_mask got %h want 0", d); end
        rd(ra(1), d);
        tests_run++; if (d !== 32'd0) begin tests_failed++; $display("FAIL reset_pending got %h want 0", d); end
        rd(ra(3), d);
        tests_run++; if (d !== 32'd0) begin tests_failed++; $display("FAIL reset_state got %h want 0", d); end
        rd(32'h0000_0008, d);
        tests_run++; if (d !== 32'd0) begin tests_failed++; $display("FAIL reset_bus_hiz got %h want undriven", d); end
    endtask

    task automatic test_latency();
        logic [31:0] d;
        wr(ra(0), 32'h01, 2'd1);
        irq[0] = 1'b1;
        cyc(1);                       // E0
        irq[0] = 1'b0;
        tests_run++; if (INTreq !== 1'b0) begin tests_failed++; $display("FAIL lat_e0_intreq got %b want 0", INTreq); end
        cyc(1);                       // E1
        rd(ra(1), d);                 // value after E1, read ends at E2
        tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL lat_pend_e1 got %h want 0", d); end
        tests_run++; if (INTreq !== 1'b0) begin tests_failed++; $display("FAIL lat_e2_intreq got %b want 0", INTreq); end
        rd(ra(1), d);                 // value after E2, read ends at E3
        tests_run++; if (d !== 32'h1) begin tests_failed++; $display("FAIL lat_pend_e2 got %h want 1", d); end
        tests_run++; if (INTreq !== 1'b1) begin tests_failed++; $display("FAIL lat_e3_intreq got %b want 1", INTreq); end
        tests_run++; if (INTnum !== 32'd16) begin tests_failed++; $display("FAIL lat_e3_intnum got %0d want 16", INTnum); end
        rd(ra(2), d);
        tests_run++; if (d !== 32'd16) begin tests_failed++; $display("FAIL lat_ack got %0d want 16", d); end
        tests_run++; if (INTreq !== 1'b0) begin tests_failed++; $display("FAIL lat_ack_intreq got %b want 0", INTreq); end
        wr(ra(3), 32'h0, 2'd1);
    endtask

    task automatic test_priority();
        logic [31:0] d;
        wr(ra(0), 32'hFF, 2'd1);
        irq = 8'h24;
        cyc(4);
        tests_run++; if (INTreq !== 1'b1 || INTnum !== 32'd18) begin tests_failed++; $display("FAIL prio_req got %b/%0d want 1/18", INTreq, INTnum); end
        rd(ra(2), d);
        tests_run++; if (d !== 32'd18) begin tests_failed++; $display("FAIL prio_ack got %0d want 18", d); end
        tests_run++; if (INTreq !== 1'b0) begin tests_failed++; $display("FAIL prio_ack_intreq got %b want 0", INTreq); end
        cyc(2);
        tests_run++; if (INTreq !== 1'b0 || INTnum !== 32'd18) begin tests_failed++; $display("FAIL prio_service got %b/%0d want 0/18", INTreq, INTnum); end
        wr(ra(3), 32'h0, 2'd1);       // Ek: back to IDLE
        tests_run++; if (INTreq !== 1'b0) begin tests_failed++; $display("FAIL b2b_ek_intreq got %b want 0", INTreq); end
        cyc(1);                       // Ek+1: REQ for line 5
        tests_run++; if (INTreq !== 1'b1 || INTnum !== 32'd21) begin tests_failed++; $display("FAIL b2b_req got %b/%0d want 1/21", INTreq, INTnum); end
        rd(ra(2), d);
        tests_run++; if (d !== 32'd21) begin tests_failed++; $display("FAIL b2b_ack got %0d want 21", d); end
        wr(ra(3), 32'h0, 2'd1);
        irq = '0;
        cyc(4);
    endtask

    task automatic test_masked();
        logic [31:0] d;
        wr(ra(0), 32'h00, 2'd1);
        irq[3] = 1'b1;
        cyc(5);
        tests_run++; if (INTreq !== 1'b0) begin tests_failed++; $display("FAIL masked_intreq got %b want 0", INTreq); end
        rd(ra(1), d);
        tests_run++; if (d !== 32'h08) begin tests_failed++; $display("FAIL masked_pending got %h want 08", d); end
        wr(ra(0), 32'h08, 2'd1);
        tests_run++; if (INTreq !== 1'b0) begin tests_failed++; $display("FAIL unmask_early got %b want 0", INTreq); end
        cyc(1);
        tests_run++; if (INTreq !== 1'b1 || INTnum !== 32'd19) begin tests_failed++; $display("FAIL unmask_req got %b/%0d want 1/19", INTreq, INTnum); end
        rd(ra(2), d);
        wr(ra(3), 32'h0, 2'd1);
        irq = '0;
        cyc(4);
    endtask

    task automatic test_sw_cancel();
        logic [31:0] d;
        wr(ra(0), 32'h02, 2'd1);
        irq[1] = 1'b1;
        cyc(4);
        tests_run++; if (INTreq !== 1'b1 || INTnum !== 32'd17) begin tests_failed++; $display("FAIL cancel_req got %b/%0d want 1/17", INTreq, INTnum); end
        wr(ra(1), 32'h02, 2'd1);
        tests_run++; if (INTreq !== 1'b0) begin tests_failed++; $display("FAIL cancel_intreq got %b want 0", INTreq); end
        rd(ra(3), d);
        tests_run++; if (d !== 32'h01) begin tests_failed++; $display("FAIL cancel_state got %h want 01", d); end
        rd(ra(2), d);
        tests_run++; if (d !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL cancel_ack got %h want ffffffff", d); end
        rd(ra(3), d);
        tests_run++; if (d !== 32'h01) begin tests_failed++; $display("FAIL cancel_ack_noeffect got %h want 01", d); end
        irq = '0;
        cyc(4);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr(ra(0), 32'h01, 2'd1);
        irq[0] = 1'b1;
        cyc(4);
        tests_run++; if (INTreq !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre got %b want 1", INTreq); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++; if (INTreq !== 1'b0 || INTnum !== 32'd0) begin tests_failed++; $display("FAIL rstmid_async got %b/%0d want 0/0", INTreq, INTnum); end
        irq = '0;
        @(negedge clk);
        rst = 1'b0;
        rd(ra(0), d);
        tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL rstmid_mask got %h want 0", d); end
        rd(ra(1), d);
        tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL rstmid_pending got %h want 0", d); end
        rd(32'h0000_0004, d);
        tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL rstmid_hiz got %h want undriven", d); end
        cyc(4);
    endtask

    task automatic test_bus();
        logic [31:0] d;
        rd((BASE ^ 32'h0000_0100) + 32'd8, d);
        tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL bus_nohit got %h want undriven", d); end
        wr(ra(0), 32'h05, 2'd1);
        wr(ra(0), 32'hA0, 2'd3);
        wr(ra(0), 32'hA0, 2'd2);
        rd(ra(0), d);
        tests_run++; if (d !== 32'h05) begin tests_failed++; $display("FAIL bus_byte_write got %h want 05", d); end
        // a read strobe alongside a write code must not drive the bus
        Addr = ra(0); Memread = 1'b1; Memwrite = 2'd3;
        #1 d = BUS;
        @(negedge clk);
        Memread = 1'b0; Memwrite = 2'd0; Addr = '0;
        tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL bus_drive_on_write got %h want undriven", d); end
        wr(ra(0), 32'h00, 2'd1);
        irq[4] = 1'b1;
        cyc(2);
        wr(ra(1), 32'h10, 2'd1);     // ends at the edge that sets pending[4]
        rd(ra(1), d);
        tests_run++; if (d !== 32'h10) begin tests_failed++; $display("FAIL set_beats_clear got %h want 10", d); end
        wr(ra(1), 32'h10, 2'd1);
        rd(ra(1), d);
        tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL w1c got %h want 0", d); end
        irq = '0;
        cyc(4);
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        int op, sel;
        for (int n = 0; n < 400; n++) begin
            tests_run++;
            if (INTreq !== m_req || INTnum !== m_num) begin
                tests_failed++;
                $display("FAIL rand_out[%0d] got %b/%0d want %b/%0d", n, INTreq, INTnum, m_req, m_num);
            end
            for (int i = 0; i < int'(NIRQ); i++)
                if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
            op = int'($urandom_range(0, 9));
            case (op)
                0: wr(ra(0), $urandom | 32'h1, 2'd1);
                1: wr(ra(1), 32'(1) << $urandom_range(0, NIRQ - 1), 2'd1);
                2, 3, 5: begin
                    sel = (op == 5) ? int'($urandom_range(0, 3)) : 2;
                    e = exp_rd(sel);
                    rd(ra(sel), d);
                    tests_run++;
                    if (d !== e) begin
                        tests_failed++;
                        $display("FAIL rand_read[%0d] reg%0d got %h want %h", n, sel, d, e);
                    end
                end
                4: wr(ra(3), $urandom, 2'd1);
                default: cyc(1);
            endcase
        end
        irq = '0;
        cyc(4);
    endtask

    initial begin
        rst = 1'b1; irq = '0; Addr = '0; Memread = 1'b0; Memwrite = 2'd0;
        tb_wdata = '0; tb_drv = 1'b0;
        cyc(2);
        rst = 1'b0;
        test_reset();
        test_latency();
        test_priority();
        test_masked();
        test_sw_cancel();
        test_reset_mid();
        test_bus();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
